// File: rtl/enable_seq_pkg.sv
// Shared types and constants for the enable sequencer.
package enable_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } seq_state_t;

    // cfg_address 0 selects the period; 1+k selects the phase of channel k
    localparam int ADDR_PERIOD = 0;

    // width of the optional burst_length input
    localparam int BURST_W = 16;

endpackage

// File: rtl/enable_seq_channel.sv
// One enable channel: shadow/active phase pair and a registered one-cycle
// pulse when the shared counter reaches the active phase.
module enable_seq_channel #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_write,
    input  logic [COUNTER_WIDTH-1:0] cfg_data,
    input  logic                     load,
    input  logic                     active,
    input  logic [COUNTER_WIDTH-1:0] counter,
    output logic                     enable
);

    logic [COUNTER_WIDTH-1:0] phase_sh;
    logic [COUNTER_WIDTH-1:0] phase_act;

    // shadow phase takes software writes at any time
    always_ff @(posedge clock) begin
        if (!reset)         phase_sh <= '0;
        else if (cfg_write) phase_sh <= cfg_data;
    end

    // active phase only moves while idle or on the period wrap
    always_ff @(posedge clock) begin
        if (!reset)    phase_act <= '0;
        else if (load) phase_act <= phase_sh;
    end

    // a phase at or beyond the period is never reached, so it stays silent
    always_ff @(posedge clock) begin
        if (!reset) enable <= 1'b0;
        else        enable <= active && (counter == phase_act);
    end

endmodule

// File: rtl/enable_sequencer.sv
// Run-control and phase scheduler: one shared period counter, per-channel
// phase-offset enable pulses, start/stop and glitch-free reconfiguration.
// Optional feature macro: ENABLE_SEQ_BURST_EN (adds burst_length/burst_done).
module enable_sequencer
    import enable_seq_pkg::*;
#(
    parameter  int N_CHANNELS    = 4,
    parameter  int COUNTER_WIDTH = 32,
    localparam int AW            = $clog2(N_CHANNELS) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     cfg_write,
    input  logic [AW-1:0]            cfg_address,
    input  logic [COUNTER_WIDTH-1:0] cfg_data,
`ifdef ENABLE_SEQ_BURST_EN
    input  logic [BURST_W-1:0]       burst_length,
    output logic                     burst_done,
`endif
    output logic [N_CHANNELS-1:0]    enable_out,
    output logic                     sync_out,
    output logic                     running,
    output logic                     cfg_error
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    seq_state_t               state, state_nxt;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [COUNTER_WIDTH-1:0] period_sh, period_act;
    logic                     active, wrap, load_act, start_err;

`ifdef ENABLE_SEQ_BURST_EN
    logic [BURST_W-1:0]       burst_left;
    logic                     stop_seen, burst_fin;
`endif

    assign active   = (state != IDLE);
    assign running  = active;
    // a zero active period can only come from a runtime write of 0; wrap
    // every cycle so the counter can never run away
    assign wrap     = active && ((period_act == '0) || (counter == period_act - CNT_ONE));
    assign load_act = (state == IDLE) || wrap;

    // next-state logic and start rejection
    always_comb begin
        state_nxt = state;
        start_err = 1'b0;
`ifdef ENABLE_SEQ_BURST_EN
        burst_fin = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (period_sh == '0)
                        start_err = 1'b1;
`ifdef ENABLE_SEQ_BURST_EN
                    // a one-period burst is already in its final period
                    else if (burst_length == BURST_W'(1))
                        state_nxt = STOPPING;
`endif
                    else
                        state_nxt = RUNNING;
                end
            end
            RUNNING: begin
                if (stop)
                    state_nxt = STOPPING;
`ifdef ENABLE_SEQ_BURST_EN
                else if (wrap && (burst_left == BURST_W'(2)))
                    state_nxt = STOPPING;
`endif
            end
            STOPPING: begin
                if (wrap) begin
                    state_nxt = IDLE;
`ifdef ENABLE_SEQ_BURST_EN
                    burst_fin = (burst_left == BURST_W'(1)) && !stop_seen;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state, counter and period shadow/active registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            counter    <= '0;
            period_sh  <= '0;
            period_act <= '0;
        end else begin
            state   <= state_nxt;
            counter <= (active && !wrap) ? counter + CNT_ONE : '0;
            if (cfg_write && (cfg_address == AW'(ADDR_PERIOD)))
                period_sh <= cfg_data;
            // nonblocking read gives the pre-write shadow on a coincident write
            if (load_act)
                period_act <= period_sh;
        end
    end

    // registered sync and error pulses
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_out  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            sync_out  <= active && (counter == '0);
            cfg_error <= start_err;
        end
    end

`ifdef ENABLE_SEQ_BURST_EN
    // burst period count (reloaded while idle, so it holds the value seen at start)
    always_ff @(posedge clock) begin
        if (!reset) begin
            burst_left <= '0;
            stop_seen  <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= burst_fin;
            if (state == IDLE) begin
                burst_left <= burst_length;
                stop_seen  <= 1'b0;
            end else if (state == RUNNING) begin
                if (wrap && (burst_left > BURST_W'(1)))
                    burst_left <= burst_left - BURST_W'(1);
                if (stop)
                    stop_seen <= 1'b1;
            end
        end
    end
`endif

    genvar k;
    generate
        for (k = 0; k < N_CHANNELS; k++) begin : g_ch
            enable_seq_channel #(
                .COUNTER_WIDTH(COUNTER_WIDTH)
            ) u_ch (
                .clock    (clock),
                .reset    (reset),
                .cfg_write(cfg_write && (cfg_address == AW'(k + 1))),
                .cfg_data (cfg_data),
                .load     (load_act),
                .active   (active),
                .counter  (counter),
                .enable   (enable_out[k])
            );
        end
    endgenerate

endmodule
